// File: rtl/if_prefetch_queue.sv
// In-order prefetch FIFO between IF and ID: holds {PC+4, instruction} pairs,
// asserts Full to freeze fetch, and drops wrong-path entries on Flush.
module if_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PC_in,
    input  logic [31:0]      Inst_in,
    input  logic             Push_Valid,
    input  logic             Freeze,
    input  logic             Flush,
    output logic [31:0]      PC_out,
    output logic [31:0]      Inst_out,
    output logic             Out_Valid,
    output logic             Full,
    output logic [PTR_W:0]   Count
);

    localparam logic [PTR_W:0] LP_FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [63:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_out_valid;
    logic             w_push_en;
    logic             w_pop_en;
    logic [63:0]      w_head;

    assign w_full      = (r_count == LP_FULL_COUNT);
    assign w_out_valid = (r_count != '0);

    // Full comes from the registered count, so a pop never frees a slot for a
    // push in the same cycle.
    assign w_push_en = Push_Valid & ~w_full & ~Flush;
    assign w_pop_en  = w_out_valid & ~Freeze & ~Flush;

    // NOTE: the storage array has no reset; validity is tracked by r_count,
    // so clearing the data would only cost flops and reset routing.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= {PC_in, Inst_in};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign PC_out    = w_out_valid ? w_head[63:32] : 32'h0;
    assign Inst_out  = w_out_valid ? w_head[31:0]  : 32'h0;
    assign Out_Valid = w_out_valid;
    assign Full      = w_full;
    assign Count     = r_count;

endmodule
